// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder_arbiter slice.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                WIDTH   = 16;
  localparam int                CNT_W   = 4;
  localparam logic [WIDTH-1:0]  SAT_VAL = 16'hFFFF;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester, result and shared-adder signals of adder_arbiter grouped as one bundle.
interface adder_arbiter_if;
  import adder_arb_pkg::*;

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             owner;
  logic             busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, add_s, add_cout,
    output gnt0, gnt1, done0, done1, add_a, add_b, result, overflow, owner, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, add_s, add_cout,
    input  gnt0, gnt1, done0, done1, add_a, add_b, result, overflow, owner, busy
  );

endinterface

// File: rtl/adder_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the index other than i_last wins.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);

  assign o_valid = |i_req;
  assign o_idx   = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/adder_arbiter.sv
// Sequencer sharing one external 16-bit adder between two requesters; every output registered.
// Build option ADDER_ARB_SATURATE_EN clamps Result to all-ones when the adder carries out.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  adder_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_owner;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_busy;
  logic             r_overflow;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_pick_vld;
  logic             w_pick_idx;
  logic             w_grant;
  logic             w_capture;

  rr_pick2 u_pick (
    .i_req   ({bus.req1, bus.req0}),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = HOLD;
      HOLD:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant   = (r_state == IDLE) && w_pick_vld;
    w_capture = (r_state == HOLD) && (r_cnt == '0);
`ifdef ADDER_ARB_SATURATE_EN
    w_res_nxt = bus.add_cout ? SAT_VAL : bus.add_s;
`else
    w_res_nxt = bus.add_s;
`endif
  end

  // A reset mid-HOLD simply drops the operation: no Done is ever produced for it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
    end else begin
      r_gnt0  <= w_grant && !w_pick_idx;
      r_gnt1  <= w_grant &&  w_pick_idx;
      r_done0 <= w_capture && !r_owner;
      r_done1 <= w_capture &&  r_owner;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_op_a  <= w_pick_idx ? bus.a1 : bus.a0;
        r_op_b  <= w_pick_idx ? bus.b1 : bus.b0;
        r_owner <= w_pick_idx;
        r_last  <= w_pick_idx;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == HOLD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_result   <= w_res_nxt;
        r_overflow <= bus.add_cout;
      end
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.add_a    = r_op_a;
  assign bus.add_b    = r_op_b;
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.owner    = r_owner;
  assign bus.busy     = r_busy;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencer and two-way arbiter that shares one 16-bit ripple adder (carry_ripple_unit) between two requesters. It accepts a request, latches the operands, and holds them on the adder for a fixed settle time. It then captures sum and carry-out into a result register and pulses a completion strobe to the winning requester. The block sits between the switch/register front end and the adder, replacing direct wiring of a single operand source.

## Interface
Parameters:
- SETTLE, default 4: cycles operands are held on the adder before capture; legal range 1–15.

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req0, Req1  in  1  requester 0/1 wants an add
- A0, B0, A1, B1  in  16  operands for each requester; sampled only at grant
- Gnt0, Gnt1  out  1  one-cycle pulse, operands of that requester latched
- Done0, Done1  out  1  one-cycle pulse, Result valid for that requester
- Add_A, Add_B  out  16  operands driven to the shared adder
- Add_S  in  16  adder sum
- Add_Cout  in  1  adder carry-out
- Result  out  16  captured sum, held until next capture
- Overflow  out  1  captured carry-out, held with Result
- Owner  out  1  requester index of the last capture
- Busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, HOLD, DONE.
- IDLE:
  - If any Req is high at an edge, pick a winner and go to HOLD.
  - Latch the winner's A/B into the operand registers, set Owner, assert that requester's Gnt, and load Cnt = SETTLE-1.
- Arbitration:
  - Single request: grant it.
  - Both requests: grant the index not equal to Last.
  - Last updates to the winner on every grant.
  - Reset sets Last = 1, so requester 0 wins the first tie.
- HOLD:
  - Add_A/Add_B are driven from the operand registers.
  - Cnt decrements each edge.
  - At the edge where Cnt == 0: capture Result/Overflow from Add_S/Add_Cout, assert Done of Owner, go to DONE.
- DONE: unconditional return to IDLE next edge. No grant is issued from DONE.
- Req changes after grant are ignored. A dropped Req still completes and still pulses Done. The requester must deassert Req on Done or it is re-arbitrated.
- Add_A/Add_B hold the last operands in IDLE; they do not follow the requester inputs.
- Arithmetic: unsigned 16-bit, carry-in 0. Overflow is the carry-out.
- Reset at any cycle, including mid-HOLD:
  - FSM goes to IDLE and the operation is discarded (no Done).
  - All outputs become 0: Gnt*, Done*, Result, Overflow, Owner, Busy, Add_A, Add_B.
  - Cnt = 0, Last = 1.

## Timing
- Edge E0: Req sampled in IDLE. After E0: Gnt high for exactly one cycle, Busy = 1.
- After edge E_SETTLE: Done high for one cycle, Result/Overflow/Owner updated in the same cycle.
- After edge E_(SETTLE+1): IDLE, Busy = 0. The earliest next grant is at edge E_(SETTLE+2).
- Throughput: one add per SETTLE+2 cycles. Gnt→Done latency is SETTLE cycles.
- Gnt0/Gnt1 and Done0/Done1 are never high together.
- All outputs are registered; there is no combinational path from Req to Gnt.

## Configuration
- Macro ADDER_ARB_SATURATE_EN.
- Defined: Result = 16'hFFFF when Add_Cout = 1, else Add_S. Overflow still reports Add_Cout.
- Undefined: Result = Add_S (wrap-around), Overflow = Add_Cout.

## Structure
- Package adder_arb_pkg:
  - state enum (IDLE, HOLD, DONE)
  - WIDTH = 16
  - SAT_VAL = 16'hFFFF
  - CNT_W = 4
- One sub-module, rr_pick2: combinational round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, idx.
- Counter, FSM and result register live in adder_arbiter.

## Test plan
1. SETTLE=4, Req0 with A0=16'h1234, B0=16'h0101:
   - Gnt0 after E0, Done0 after E4
   - Result=16'h1335, Overflow=0, Owner=0
2. Req0 and Req1 raised on the same edge, both held:
   - grants go 0, then 1, then 0 (alternating)
   - each grant follows 6 cycles after the previous one
3. A1=16'hFFFF, B1=16'h0002:
   - without the macro: Result=16'h0001, Overflow=1
   - with ADDER_ARB_SATURATE_EN: Result=16'hFFFF, Overflow=1
4. Reset asserted while Cnt=2 in HOLD:
   - no Done pulse
   - all outputs 0 the next cycle
   - a following tie grants requester 0
5. Req0 dropped the cycle after Gnt0; operands changed after grant:
   - Done0 still pulses
   - Result uses the latched operands
   - no second grant occurs
6. SETTLE=1, single Req1:
   - Gnt1 after E0, Done1 after E1, Busy low after E2
